// File: rtl/add_special_result_pkg.sv
// Shared case codes and default widths for the FP adder special-result path.
package add_special_result_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefWsig  = 23;

  typedef enum logic [2:0] {
    CaseNone   = 3'd0,
    CaseNan    = 3'd1,
    CaseInfInv = 3'd2,
    CaseAinf   = 3'd3,
    CaseBinf   = 3'd4
  } case_e;

endpackage

// File: rtl/add_special_result_nan_select.sv
// Picks the NaN operand (a when a is NaN, else b) and quiets it, keeping sign and payload.
module add_special_result_nan_select #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned WSIG  = 23
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             anan,
  output logic [WIDTH-1:0] nan_q
);

  always_comb begin
    nan_q = anan ? a : b;
    nan_q[WSIG-1] = 1'b1;
  end

endmodule

// File: rtl/add_special_result.sv
// Two-stage valid/ready pipeline producing the FP adder special-input result and invalid flag.
// Optional QNAN_PAYLOAD_EN: NaN results propagate the quieted input NaN instead of canonical qNaN.
module add_special_result
  import add_special_result_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned WSIG  = DefWsig
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             ainf,
  input  logic             binf,
  input  logic             anan,
  input  logic             bnan,
  input  logic             asignan,
  input  logic             bsignan,
  input  logic             specinput,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_special,
  output logic             out_invalid
);

  localparam int unsigned WEXP = WIDTH - WSIG - 1;
  localparam logic [WIDTH-1:0] QnanCanon = {1'b0, {WEXP{1'b1}}, 1'b1, {(WSIG - 1){1'b0}}};

  logic             r_s1_valid;
  case_e            r_s1_code;
  logic             r_s1_sa;
  logic             r_s1_sb;
  logic             r_s1_invalid;

  logic             w_sb;
  logic             w_s1_adv;
  logic             w_s2_adv;
  case_e            w_code;
  logic             w_invalid;
  logic [WIDTH-1:0] w_result;
  logic             w_special;

  assign w_sb     = b[WIDTH-1] ^ sub;
  assign w_s2_adv = ~out_valid | out_ready;
  assign w_s1_adv = r_s1_valid & w_s2_adv;
  assign in_ready = ~r_s1_valid | w_s1_adv;

`ifdef QNAN_PAYLOAD_EN
  logic [WIDTH-1:0] w_nan;
  logic [WIDTH-1:0] r_s1_nan;

  add_special_result_nan_select #(
    .WIDTH(WIDTH),
    .WSIG (WSIG)
  ) u_nan_select (
    .a    (a),
    .b    (b),
    .anan (anan),
    .nan_q(w_nan)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_nan <= '0;
    end else if (in_ready && in_valid) begin
      r_s1_nan <= w_nan;
    end
  end
`else
  // Only the sign bits of the operands matter when NaNs are canonicalised.
  logic w_unused_opnd;
  assign w_unused_opnd = ^{a[WIDTH-2:0], b[WIDTH-2:0]};
`endif

  // Flags are trusted as given; NaN outranks infinity handling.
  always_comb begin
    w_code    = CaseNone;
    w_invalid = 1'b0;
    if (specinput) begin
      if (anan || bnan) begin
        w_code    = CaseNan;
        w_invalid = asignan | bsignan;
      end else if (ainf && binf) begin
        if (a[WIDTH-1] != w_sb) begin
          w_code    = CaseInfInv;
          w_invalid = 1'b1;
        end else begin
          w_code = CaseAinf;
        end
      end else if (ainf) begin
        w_code = CaseAinf;
      end else if (binf) begin
        w_code = CaseBinf;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_code    <= CaseNone;
      r_s1_sa      <= 1'b0;
      r_s1_sb      <= 1'b0;
      r_s1_invalid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_code    <= w_code;
        r_s1_sa      <= a[WIDTH-1];
        r_s1_sb      <= w_sb;
        r_s1_invalid <= w_invalid;
      end
    end
  end

  always_comb begin
    w_result  = '0;
    w_special = 1'b1;
    unique case (r_s1_code)
`ifdef QNAN_PAYLOAD_EN
      CaseNan:    w_result = r_s1_nan;
`else
      CaseNan:    w_result = QnanCanon;
`endif
      CaseInfInv: w_result = QnanCanon;
      CaseAinf:   w_result = {r_s1_sa, {WEXP{1'b1}}, {WSIG{1'b0}}};
      CaseBinf:   w_result = {r_s1_sb, {WEXP{1'b1}}, {WSIG{1'b0}}};
      default:    w_special = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_special <= 1'b0;
      out_invalid <= 1'b0;
    end else if (w_s2_adv) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_result  <= w_result;
        out_special <= w_special;
        out_invalid <= r_s1_invalid & w_special;
      end
    end
  end

endmodule

// File: tb/tb_add_special_result.sv
// Scoreboard bench for add_special_result: directed vectors, stall, latency and reset checks.
module tb_add_special_result;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        ainf = 1'b0, binf = 1'b0, anan = 1'b0, bnan = 1'b0;
  logic        asignan = 1'b0, bsignan = 1'b0, specinput = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_special;
  logic        out_invalid;

  int tests = 0;
  int fails = 0;

  logic [33:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [33:0] held = '0;

  always #5 clk = ~clk;

  add_special_result u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sub        (sub),
    .ainf       (ainf),
    .binf       (binf),
    .anan       (anan),
    .bnan       (bnan),
    .asignan    (asignan),
    .bsignan    (bsignan),
    .specinput  (specinput),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_special(out_special),
    .out_invalid(out_invalid)
  );

  // Monitor: pops the scoreboard on each transfer and checks hold-stability while stalled.
  always @(negedge clk) begin
    logic [33:0] e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests++;
        if (!out_valid || {out_result, out_special, out_invalid} != held) begin
          fails++;
          $display("FAIL stall_stable: got v=%0b %h/%0b/%0b want held %h/%0b/%0b", out_valid,
                   out_result, out_special, out_invalid, held[33:2], held[1], held[0]);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got %h/%0b/%0b want no beat", out_result, out_special,
                   out_invalid);
        end else begin
          e = exp_q.pop_front();
          if ({out_result, out_special, out_invalid} != e) begin
            fails++;
            $display("FAIL beat: got %h/%0b/%0b want %h/%0b/%0b", out_result, out_special,
                     out_invalid, e[33:2], e[1], e[0]);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {out_result, out_special, out_invalid};
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                      input logic [5:0] fl, input logic [31:0] er, input logic es,
                      input logic ei);
    bit ok = 1'b0;
    a = ia; b = ib; sub = isub;
    {ainf, binf, anan, bnan, asignan, bsignan} = fl;
    specinput = fl[5] | fl[4] | fl[3] | fl[2];
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        exp_q.push_back({er, es, ei});
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles want accept");
    end
  endtask

  // Flag order: {ainf, binf, anan, bnan, asignan, bsignan}
  localparam logic [5:0] FAinf = 6'b100000, FBinf = 6'b010000, FBoth = 6'b110000;
  localparam logic [5:0] FNone = 6'b000000;

`ifdef QNAN_PAYLOAD_EN
  localparam logic [31:0] Exp3 = 32'h7FC00001, Exp6 = 32'hFFE00005;
  localparam logic [31:0] Exp7 = 32'h7FC00123, Exp8 = 32'hFFC00000;
`else
  localparam logic [31:0] Exp3 = 32'h7FC00000, Exp6 = 32'h7FC00000;
  localparam logic [31:0] Exp7 = 32'h7FC00000, Exp8 = 32'h7FC00000;
`endif

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_result", out_result, 0);
    check("rst_flags", {30'd0, out_special, out_invalid}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Latency: driven after edge N, accepted at N+1, out_valid after N+2.
    send(32'h7F800000, 32'h3F800000, 1'b0, FAinf, 32'h7F800000, 1'b1, 1'b0);
    @(negedge clk);
    check("latency_n1", {31'd0, out_valid}, 0);
    @(posedge clk);
    #1;
    check("latency_n2", {31'd0, out_valid}, 1);
    drain();

    send(32'h7F800000, 32'hFF800000, 1'b0, FBoth, 32'h7FC00000, 1'b1, 1'b1);
    send(32'h7F800000, 32'h7F800000, 1'b1, FBoth, 32'h7FC00000, 1'b1, 1'b1);
    send(32'h7F800001, 32'h3F800000, 1'b0, 6'b001010, Exp3, 1'b1, 1'b1);
    send(32'h3F800000, 32'h7F800000, 1'b1, FBinf, 32'hFF800000, 1'b1, 1'b0);
    send(32'h3F800000, 32'h40000000, 1'b0, FNone, 32'h00000000, 1'b0, 1'b0);
    send(32'hFF800000, 32'h7F800000, 1'b1, FBoth, 32'hFF800000, 1'b1, 1'b0);
    send(32'h3F800000, 32'hFFA00005, 1'b0, 6'b000101, Exp6, 1'b1, 1'b1);
    send(32'h7FC00123, 32'h7F800000, 1'b0, 6'b011000, Exp7, 1'b1, 1'b0);
    send(32'hFFC00000, 32'h7FA00000, 1'b0, 6'b001101, Exp8, 1'b1, 1'b1);
    drain();

    // Backpressure: two beats fill both stages, then in_ready must drop.
    out_ready = 1'b0;
    send(32'h7F800000, 32'h3F800000, 1'b0, FAinf, 32'h7F800000, 1'b1, 1'b0);
    send(32'h3F800000, 32'h7F800000, 1'b1, FBinf, 32'hFF800000, 1'b1, 1'b0);
    @(negedge clk);
    check("stall_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1;
    fork
      begin
        send(32'hFF800000, 32'h7F800000, 1'b1, FBoth, 32'hFF800000, 1'b1, 1'b0);
        send(32'h3F800000, 32'h40000000, 1'b0, FNone, 32'h00000000, 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight drops them.
    out_ready = 1'b0;
    send(32'h7F800000, 32'h3F800000, 1'b0, FAinf, 32'h7F800000, 1'b1, 1'b0);
    send(32'h7F800000, 32'hFF800000, 1'b0, FBoth, 32'h7FC00000, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_out_valid", {31'd0, out_valid}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    check("reset_in_ready", {31'd0, in_ready}, 1);
    repeat (6) @(posedge clk);
    #1;
    check("reset_no_stale", {31'd0, out_valid}, 0);

    send(32'h3F800000, 32'h7F800000, 1'b1, FBinf, 32'hFF800000, 1'b1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
